// File: rtl/vga_scanout.sv
// vga_scanout
//   Display-side reader for a frame buffer. Runs the VGA raster counters,
//   fetches every visible pixel over a fixed-latency read port and drives
//   sync, data-enable and 8:8:8 RGB with sync/DE aligned to the pixel data.
//
// Ports
//   clk_display    in   pixel clock, all logic on its rising edge
//   rst_n          in   asynchronous active-low reset
//   enable         in   1 = scan; 0 = hold raster at origin, pins blank
//   rd_en          out  fetch strobe, visible pixels only
//   rd_x / rd_y    out  fetch column / row, valid while rd_en=1
//   rd_data        in   {R,G,B} returned RD_LATENCY clocks after rd_en
//   rd_valid       in   rd_data qualifier, sampled RD_LATENCY clocks after rd_en
//   clr_underflow  in   clears the sticky underflow flag
//   vga_hsync/vsync out active-low syncs
//   vga_de         out  visible-pixel qualifier
//   vga_r/g/b      out  colour, forced to 0 outside the visible area
//   frame_start    out  one-clock pulse when pixel (0,0) is at the pins
//   underflow      out  sticky: a visible pixel arrived without rd_valid
//
// RD_LATENCY must be in 1..4.

module vga_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk_display,
  input  logic        rst_n,
  input  logic        enable,
  output logic        rd_en,
  output logic [9:0]  rd_x,
  output logic [8:0]  rd_y,
  input  logic [23:0] rd_data,
  input  logic        rd_valid,
  input  logic        clr_underflow,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start,
  output logic        underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  // Sync windows are [start, end) in counter units.
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Colour shown for a visible pixel whose fetch did not come back.
  localparam logic [23:0] MISSING_RGB = 24'hFF00FF;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic org;
  } tap_t;

  // ---------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------
  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (!enable) begin
      hc_d = '0;
      vc_d = '0;
    end else if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
    end else begin
      hc_d = hc_q + 10'd1;
    end
  end

  always_ff @(posedge clk_display or negedge rst_n) begin
    if (!rst_n) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage-0 decode and fetch request
  // ---------------------------------------------------------------------
  tap_t stage0;

  always_comb begin
    stage0.act = (hc_q < H_ACT_END) && (vc_q < V_ACT_END);
    stage0.hs  = (hc_q >= HS_START) && (hc_q < HS_END);
    stage0.vs  = (vc_q >= VS_START) && (vc_q < VS_END);
    stage0.org = (hc_q == '0) && (vc_q == '0);
  end

  assign rd_en = enable && stage0.act;
  assign rd_x  = hc_q;
  assign rd_y  = vc_q[8:0];

  // ---------------------------------------------------------------------
  // Delay line: carries raster flags alongside the outstanding fetch so
  // that the last tap lines up with rd_data/rd_valid. Dropping enable
  // flushes every tap, so no stale pixel can reach the pins later.
  // ---------------------------------------------------------------------
  tap_t dly_q [RD_LATENCY];
  tap_t dly_d [RD_LATENCY];
  tap_t last;

  always_comb begin
    for (int i = 0; i < RD_LATENCY; i++) begin
      dly_d[i] = '0;
    end
    if (enable) begin
      dly_d[0] = stage0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        dly_d[i] = dly_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_display or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        dly_q[i] <= dly_d[i];
      end
    end
  end

  assign last = dly_q[RD_LATENCY-1];

  // ---------------------------------------------------------------------
  // Output registers: load on the edge where the last tap and the read
  // response are sampled together, giving RD_LATENCY+1 clocks from rd_en
  // to pins for data and for sync/DE/frame_start alike.
  // ---------------------------------------------------------------------
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic        fs_q, fs_d;
  logic [23:0] rgb_q, rgb_d;
  logic        underflow_q, underflow_d;
  logic        uf_set;

  always_comb begin
    hsync_d = 1'b1;
    vsync_d = 1'b1;
    de_d    = 1'b0;
    fs_d    = 1'b0;
    rgb_d   = '0;
    if (enable) begin
      hsync_d = ~last.hs;
      vsync_d = ~last.vs;
      de_d    = last.act;
      fs_d    = last.org;
      if (last.act) begin
        rgb_d = rd_valid ? rd_data : MISSING_RGB;
      end
    end
  end

  // A new miss wins over a simultaneous clear so no event is lost.
  always_comb begin
    uf_set      = enable && last.act && !rd_valid;
    underflow_d = underflow_q;
    if (uf_set) begin
      underflow_d = 1'b1;
    end else if (clr_underflow) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_display or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      de_q        <= 1'b0;
      fs_q        <= 1'b0;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      fs_q        <= fs_d;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
    end
  end

  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_de      = de_q;
  assign frame_start = fs_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_scanout.sv
`timescale 1ns/1ps
// Four scanout instances share enable/reset stimulus: instance 0 uses the
// full 800x525 geometry with RD_LATENCY=2, instances 1..3 a reduced
// geometry with RD_LATENCY 2, 1 and 4 so that several whole frames fit in
// the run. Each instance has its own frame-buffer model and its own
// reference model working from a linear raster position.
module tb_vga_scanout;

  logic clk_display = 1'b0;
  always #5 clk_display = ~clk_display;

  logic rst_n;
  logic enable;
  logic clr_glob;
  logic clr_on_drop;
  logic drop_target;
  logic drop_rand;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_inst
    localparam bit BIG = (gi == 0);
    localparam int LAT = (gi == 2) ? 1 : ((gi == 3) ? 4 : 2);
    localparam int HA  = BIG ? 640 : 24;
    localparam int HF  = BIG ? 16  : 3;
    localparam int HSW = BIG ? 96  : 5;
    localparam int HB  = BIG ? 48  : 4;
    localparam int VA  = BIG ? 480 : 10;
    localparam int VF  = BIG ? 10  : 2;
    localparam int VSW = 2;
    localparam int VB  = BIG ? 33  : 3;
    localparam int HT  = HA + HF + HSW + HB;
    localparam int VT  = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;

    logic        rd_en, rd_valid, clr_i;
    logic [9:0]  rd_x;
    logic [8:0]  rd_y;
    logic [23:0] rd_data;
    logic        hsync, vsync, de, fs, uf;
    logic [7:0]  r, g, b;

    vga_scanout #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
      .RD_LATENCY(LAT)
    ) u_dut (
      .clk_display  (clk_display),
      .rst_n        (rst_n),
      .enable       (enable),
      .rd_en        (rd_en),
      .rd_x         (rd_x),
      .rd_y         (rd_y),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .clr_underflow(clr_i),
      .vga_hsync    (hsync),
      .vga_vsync    (vsync),
      .vga_de       (de),
      .vga_r        (r),
      .vga_g        (g),
      .vga_b        (b),
      .frame_start  (fs),
      .underflow    (uf)
    );

    // Per-cycle history (ring of 8 cycles): was the scan running, where
    // was it, was the fetch dropped, was reset held, was clear asserted.
    int   pos_cur;
    bit   uf_exp;
    bit   rec_ok   [8];
    int   rec_pos  [8];
    bit   rec_drop [8];
    bit   rec_rst  [8];
    bit   rec_clr  [8];
    // Outstanding read requests as seen by the frame-buffer model.
    bit         req_v    [8];
    logic [9:0] req_x    [8];
    logic [8:0] req_y    [8];
    bit         req_drop [8];

    initial begin
      int k;
      rd_data  = '0;
      rd_valid = 1'b0;
      clr_i    = 1'b0;
      pos_cur  = 0;
      uf_exp   = 1'b0;
      for (int i = 0; i < 8; i++) begin
        rec_ok[i] = 0; rec_pos[i] = 0; rec_drop[i] = 0; rec_rst[i] = 1; rec_clr[i] = 0;
        req_v[i] = 0; req_x[i] = '0; req_y[i] = '0; req_drop[i] = 0;
      end
      k = 0;
      forever begin
        int          prev, src, p, x, y, ri;
        bit          all_ok, a, set, rs, en, ok, drop_c, dropping;
        bit          e_hs, e_vs, e_de, e_fs;
        logic [23:0] e_rgb;
        logic [28:0] pins_obs, pins_exp;
        logic [19:0] rd_obs, rd_exp;

        @(posedge clk_display);
        k++;
        #1;
        // Pins now show the pixel scanned LAT+1 cycles ago, provided the
        // scan ran without a break across that whole window.
        prev   = (k - 1) & 7;
        all_ok = 1;
        for (int j = 1; j <= LAT + 1; j++) if (!rec_ok[(k - j) & 7]) all_ok = 0;
        e_hs = 1; e_vs = 1; e_de = 0; e_fs = 0; e_rgb = '0; set = 0;
        if (all_ok) begin
          src  = (k - LAT - 1) & 7;
          p    = rec_pos[src];
          x    = p % HT;
          y    = p / HT;
          a    = (x < HA) && (y < VA);
          e_de = a;
          e_hs = !((x >= HA + HF) && (x < HA + HF + HSW));
          e_vs = !((y >= VA + VF) && (y < VA + VF + VSW));
          e_fs = (p == 0);
          if (a) e_rgb = rec_drop[src] ? 24'hFF00FF : {x[7:0], y[7:0], 8'h5A};
          set  = a && rec_drop[src];
        end
        if (rec_rst[prev])      uf_exp = 0;
        else if (set)           uf_exp = 1;
        else if (rec_clr[prev]) uf_exp = 0;
        pins_exp = {e_hs, e_vs, e_de, e_fs, uf_exp, e_rgb};
        pins_obs = {hsync, vsync, de, fs, uf, r, g, b};
        pos_cur  = rec_ok[prev] ? (rec_pos[prev] + 1) % FRAME : 0;

        #2;
        rs = !rst_n;
        en = enable;
        if (rs) begin
          pos_cur = 0;
          check_eq($sformatf("inst%0d cyc%0d async_reset_pins", gi, k),
                   {35'h0, hsync, vsync, de, fs, uf, r, g, b},
                   {35'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0});
        end
        x  = pos_cur % HT;
        y  = pos_cur / HT;
        a  = (x < HA) && (y < VA);
        ok = en && !rs;
        drop_c = ok && a && ((drop_target && x == 10 && y == 3) ||
                             (drop_rand && $urandom_range(63) == 0));

        // Frame-buffer model answers the request issued LAT cycles ago;
        // with nothing outstanding it drives noise that must be ignored.
        ri = (k - LAT) & 7;
        dropping = 0;
        if (req_v[ri]) begin
          if (req_drop[ri]) begin
            rd_valid = 1'b0;
            rd_data  = 24'($urandom);
            dropping = 1;
          end else begin
            rd_valid = 1'b1;
            rd_data  = {req_x[ri][7:0], req_y[ri][7:0], 8'h5A};
          end
        end else begin
          rd_valid = 1'($urandom_range(1));
          rd_data  = 24'($urandom);
        end
        clr_i = clr_glob || (clr_on_drop && dropping);

        rd_obs = {rd_en, rd_en ? rd_x : 10'd0, rd_en ? rd_y : 9'd0};
        rd_exp = {ok && a, (ok && a) ? x[9:0] : 10'd0, (ok && a) ? y[8:0] : 9'd0};
        check_eq($sformatf("inst%0d cyc%0d pos%0d pins+fetch", gi, k, pos_cur),
                 {15'h0, pins_obs, rs ? 20'h0 : rd_obs},
                 {15'h0, pins_exp, rs ? 20'h0 : rd_exp});

        req_v[k & 7]    = rd_en && !rs;
        req_x[k & 7]    = rd_x;
        req_y[k & 7]    = rd_y;
        req_drop[k & 7] = drop_c;
        rec_ok[k & 7]   = ok;
        rec_pos[k & 7]  = pos_cur;
        rec_drop[k & 7] = drop_c;
        rec_rst[k & 7]  = rs;
        rec_clr[k & 7]  = clr_i;
      end
    end
  end

  // Returns at edge+2 of a cycle, where shared inputs may be changed.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk_display);
      #2;
    end
  endtask

  initial begin
    bit hit;
    rst_n       = 1'b0;
    enable      = 1'b0;
    clr_glob    = 1'b0;
    clr_on_drop = 1'b0;
    drop_target = 1'b0;
    drop_rand   = 1'b0;
    cycles(3);

    $display("phase: release reset with enable=1, drop pixel (10,3)");
    rst_n       = 1'b1;
    enable      = 1'b1;
    drop_target = 1'b1;
    cycles(2600);

    $display("phase: clear underflow, then drops with same-cycle clear");
    drop_target = 1'b0;
    clr_glob    = 1'b1;
    cycles(1);
    clr_glob    = 1'b0;
    drop_rand   = 1'b1;
    clr_on_drop = 1'b1;
    cycles(1500);
    clr_on_drop = 1'b0;

    $display("phase: random drops and random clears");
    repeat (1200) begin
      clr_glob = ($urandom_range(31) == 0);
      cycles(1);
    end
    drop_rand = 1'b0;
    clr_glob  = 1'b1;
    cycles(1);
    clr_glob  = 1'b0;

    $display("phase: disable at hc=300 of the full-size raster, then re-enable");
    hit = 0;
    for (int t = 0; t < 2000 && !hit; t++) begin
      if (g_inst[0].pos_cur % 800 == 300 && g_inst[0].pos_cur >= 800) hit = 1;
      else cycles(1);
    end
    check_eq("reach_hc300", {63'h0, hit}, 64'h1);
    enable = 1'b0;
    cycles($urandom_range(5, 20));
    enable = 1'b1;
    cycles(2000);

    for (int it = 0; it < 30; it++) begin
      int kind;
      kind = $urandom_range(2);
      if (kind == 0) begin
        $display("phase: random enable gap, iteration %0d", it);
        enable = 1'b0;
        cycles($urandom_range(1, 12));
        enable = 1'b1;
      end else if (kind == 1) begin
        $display("phase: random reset pulse, iteration %0d", it);
        rst_n = 1'b0;
        cycles($urandom_range(1, 3));
        rst_n = 1'b1;
      end else begin
        $display("phase: random drops window, iteration %0d", it);
        drop_rand = 1'b1;
      end
      repeat ($urandom_range(50, 500)) begin
        clr_glob = ($urandom_range(40) == 0);
        cycles(1);
      end
      drop_rand = 1'b0;
      clr_glob  = 1'b0;
    end

    cycles(10);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
